sync_ram_dp: RTL and testbench

Parametrised simple-dual-port synchronous RAM: the next generation of the team's single-port 1K×8 memory. It has one write port and one read port on a single clock. It adds per-byte write enables, a selectable read latency with a read-valid strobe, and a hardware clear engine that zero-fills the array after reset or on request. It sits in the datapath as a general scratch/buffer memory behind any controller that needs concurrent read and write.

---
 rtl/sync_ram_pkg.sv | 28 ++
 rtl/sync_ram_clear_fsm.sv | 63 ++++++
 rtl/sync_ram_dp.sv | 108 ++++++++++
 tb/tb_sync_ram_dp.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_ram_pkg.sv
// Shared types and elaboration helpers for the simple-dual-port RAM.
package sync_ram_pkg;

  // Clear engine states: CLEAR sweeps the array to zero, IDLE serves accesses.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Width of one byte lane covered by a single write-enable bit.
  localparam int BYTE_W = 8;

  // Number of byte lanes (BE_W) for a given word width.
  function automatic int be_width(input int data_w);
    return data_w / BYTE_W;
  endfunction

  // Only one- and two-cycle read pipelines exist.
  function automatic bit latency_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  // Words must split into whole byte lanes.
  function automatic bit width_legal(input int data_w);
    return (data_w > 0) && ((data_w % BYTE_W) == 0);
  endfunction

endpackage

// File: rtl/sync_ram_clear_fsm.sv
// Clear engine: sweeps every address with zero after reset or on request,
// and tells the user ports when they may access the array.
module sync_ram_clear_fsm
  import sync_ram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;

  // State and sweep counter; reset restarts the sweep from address 0.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, counter advance and port outputs.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    clr_we    = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_we  = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_ADDR) state_nxt = IDLE;
      end
      IDLE: begin
        ready = 1'b1;
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/sync_ram_dp.sv
// Simple-dual-port synchronous RAM: one write port with byte enables, one
// read port with 1- or 2-cycle latency, and a zero-fill clear engine.
module sync_ram_dp
  import sync_ram_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  clr_req,
  output logic                  ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = be_width(DATA_W);

  // Reject unsupported configurations at elaboration.
  if (!latency_legal(READ_LATENCY)) begin : g_bad_latency
    $error("sync_ram_dp: READ_LATENCY must be 1 or 2");
  end
  if (!width_legal(DATA_W)) begin : g_bad_width
    $error("sync_ram_dp: DATA_W must be a positive multiple of 8");
  end

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_acc;
  logic              rd_acc;

  sync_ram_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_acc = cs & wr_en & ready;
  assign rd_acc = cs & rd_en & ready;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write: the clear engine owns the port while sweeping, otherwise
  // accepted user writes update only the enabled byte lanes.
  // NOTE: the array has no reset; a reset cannot touch every word in one
  // cycle, so the clear engine provides defined contents instead.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) mem[wr_addr][BYTE_W*b +: BYTE_W] <= wr_data[BYTE_W*b +: BYTE_W];
      end
    end
  end

  logic [DATA_W-1:0] s1_data;
  logic              s1_valid;

  // First read stage: captures the pre-write word, giving read-first on a
  // same-address collision; data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) s1_data <= mem[rd_addr];
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_W-1:0] s2_data;
    logic              s2_valid;

    // Output register stage; only newly read words replace the held value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_data  <= '0;
        s2_valid <= 1'b0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign rd_data  = s2_data;
    assign rd_valid = s2_valid;
  end else begin : g_lat1
    assign rd_data  = s1_data;
    assign rd_valid = s1_valid;
  end

endmodule

// File: tb/tb_sync_ram_dp.sv
// Self-checking bench for sync_ram_dp: two instances (read latency 1 and 2)
// share stimulus; a behavioural model feeds per-instance expected-read queues.
module tb_sync_ram_dp;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int BW    = 2;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          cs      = 1'b0;
  logic          wr_en   = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [BW-1:0] wr_be   = '0;
  logic          rd_en   = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          clr_req = 1'b0;

  logic [DW-1:0] rd_data1, rd_data2;
  logic          rd_valid1, rd_valid2;
  logic          ready1, ready2;

  sync_ram_dp #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .clr_req(clr_req), .ready(ready1)
  );

  sync_ram_dp #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .clr_req(clr_req), .ready(ready2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
    logic          has_exp;
    logic [DW-1:0] exp;
  } rd_item_t;

  typedef struct {
    logic          c;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [BW-1:0] be;
    logic          re;
    logic [AW-1:0] ra;
    logic          chk;
    logic [DW-1:0] exp;
  } vec_t;

  rd_item_t      q1[$];
  rd_item_t      q2[$];
  rd_item_t      it;
  int            vectors     = 0;
  int            miscompares = 0;
  int            cyc         = 0;
  logic [DW-1:0] mmem [DEPTH];
  logic          m_ready     = 1'b0;
  int            clr_left    = DEPTH;
  logic [DW-1:0] hold1       = '0;
  logic [DW-1:0] hold2       = '0;
  logic          tag_valid   = 1'b0;
  logic [DW-1:0] tag_exp     = '0;
  vec_t          tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: clear sweep countdown, array image, expected reads.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready  = 1'b0;
      clr_left = DEPTH;
      q1.delete();
      q2.delete();
    end else begin
      cyc++;
      if (m_ready) begin
        if (cs && rd_en) begin
          it.data    = mmem[rd_addr];
          it.has_exp = tag_valid;
          it.exp     = tag_exp;
          it.due     = cyc;
          q1.push_back(it);
          it.due     = cyc + 1;
          q2.push_back(it);
        end
        if (cs && wr_en)
          for (int b = 0; b < BW; b++)
            if (wr_be[b]) mmem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
        if (clr_req) begin
          m_ready  = 1'b0;
          clr_left = DEPTH;
        end
      end else begin
        mmem[DEPTH - clr_left] = '0;
        clr_left--;
        if (clr_left == 0) m_ready = 1'b1;
      end
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold1 = '0;
      hold2 = '0;
      check("reset_ready", {ready1, ready2}, 2'b00);
      check("reset_valid", {rd_valid1, rd_valid2}, 2'b00);
      check("reset_data1", rd_data1, 0);
      check("reset_data2", rd_data2, 0);
    end else begin
      check("ready1", ready1, m_ready);
      check("ready2", ready2, m_ready);
      if (q1.size() > 0 && q1[0].due == cyc) begin
        check("rd_valid_l1", rd_valid1, 1);
        check("rd_data_l1", rd_data1, q1[0].data);
        if (q1[0].has_exp) check("rd_table_l1", rd_data1, q1[0].exp);
        hold1 = q1[0].data;
        void'(q1.pop_front());
      end else begin
        check("rd_idle_valid_l1", rd_valid1, 0);
        check("rd_hold_l1", rd_data1, hold1);
      end
      if (q2.size() > 0 && q2[0].due == cyc) begin
        check("rd_valid_l2", rd_valid2, 1);
        check("rd_data_l2", rd_data2, q2[0].data);
        if (q2[0].has_exp) check("rd_table_l2", rd_data2, q2[0].exp);
        hold2 = q2[0].data;
        void'(q2.pop_front());
      end else begin
        check("rd_idle_valid_l2", rd_valid2, 0);
        check("rd_hold_l2", rd_data2, hold2);
      end
    end
  end

  task automatic op(input logic c, input logic we, input logic [AW-1:0] wa,
                    input logic [DW-1:0] wd, input logic [BW-1:0] be,
                    input logic re, input logic [AW-1:0] ra, input logic clr,
                    input logic tv, input logic [DW-1:0] te);
    @(negedge clk);
    cs = c; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra; clr_req = clr; tag_valid = tv; tag_exp = te;
  endtask

  task automatic idle(input int n);
    repeat (n) op(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic quiet_inputs();
    cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0; tag_valid = 1'b0;
  endtask

  // Called right after rst_n release: ready low through edge 15, high after 16.
  task automatic sweep_check();
    for (int i = 0; i < DEPTH - 1; i++) begin
      @(negedge clk);
      check("sweep_ready_low", {ready1, ready2}, 2'b00);
    end
    @(negedge clk);
    check("sweep_ready_high", {ready1, ready2}, 2'b11);
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < DEPTH; a++) begin
      logic [AW-1:0] ra;
      ra = a[AW-1:0];
      op(1'b1, 1'b0, '0, '0, '0, 1'b1, ra, 1'b0, 1'b1, 16'h0000);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //        cs    we    wa     wd        be     re    ra     chk   exp
    tbl[0]  = '{1'b1, 1'b1, 4'd3,  16'hABCD, 2'b01, 1'b0, 4'd0,  1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd3,  1'b1, 16'h00CD};
    tbl[2]  = '{1'b1, 1'b1, 4'd3,  16'h1234, 2'b10, 1'b0, 4'd0,  1'b0, 16'h0000};
    tbl[3]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd3,  1'b1, 16'h12CD};
    tbl[4]  = '{1'b1, 1'b1, 4'd7,  16'h1111, 2'b11, 1'b0, 4'd0,  1'b0, 16'h0000};
    tbl[5]  = '{1'b1, 1'b1, 4'd7,  16'h5555, 2'b11, 1'b1, 4'd7,  1'b1, 16'h1111};
    tbl[6]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd7,  1'b1, 16'h5555};
    tbl[7]  = '{1'b1, 1'b1, 4'd7,  16'hFFFF, 2'b00, 1'b0, 4'd0,  1'b0, 16'h0000};
    tbl[8]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd7,  1'b1, 16'h5555};
    tbl[9]  = '{1'b0, 1'b1, 4'd7,  16'h0000, 2'b11, 1'b1, 4'd3,  1'b0, 16'h0000};
    tbl[10] = '{1'b1, 1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd7,  1'b1, 16'h5555};
    tbl[11] = '{1'b1, 1'b1, 4'd15, 16'hBEEF, 2'b11, 1'b1, 4'd15, 1'b1, 16'h0000};
    tbl[12] = '{1'b1, 1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd15, 1'b1, 16'hBEEF};

    // Power-up: hold reset, release between edges, watch the sweep.
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    sweep_check();
    read_all_zero();
    idle(3);

    // Byte enables, read-first collision, no-op enables, deselected port.
    foreach (tbl[i])
      op(tbl[i].c, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be,
         tbl[i].re, tbl[i].ra, 1'b0, tbl[i].chk, tbl[i].exp);
    idle(3);

    // Clear request with a same-cycle read (old data) and write (then wiped).
    op(1'b1, 1'b1, 4'd5, 16'h7777, 2'b11, 1'b0, '0, 1'b0, 1'b0, '0);
    op(1'b1, 1'b1, 4'd9, 16'hAAAA, 2'b11, 1'b1, 4'd3, 1'b1, 1'b1, 16'h12CD);
    repeat (DEPTH) op(1'b1, 1'b1, 4'd9, 16'hFFFF, 2'b11, 1'b1, 4'd3, 1'b0, 1'b0, '0);
    read_all_zero();
    idle(3);

    // Reset during an in-flight latency-2 read, then again mid-sweep.
    op(1'b1, 1'b1, 4'd5, 16'h7777, 2'b11, 1'b0, '0, 1'b0, 1'b0, '0);
    op(1'b1, 1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0, 1'b1, 16'h7777);
    @(posedge clk);
    #2 rst_n = 1'b0;
    quiet_inputs();
    #1;
    check("async_reset_valid", {rd_valid1, rd_valid2}, 2'b00);
    check("async_reset_data", {rd_data1, rd_data2}, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("mid_sweep_reset_ready", {ready1, ready2}, 2'b00);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    sweep_check();
    op(1'b1, 1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0, 1'b1, 16'h0000);
    op(1'b1, 1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0, 1'b1, 16'h0000);
    idle(4);

    check("queue_drain", q1.size() + q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
